// File: rtl/pq_request_arbiter.sv
// rtl/pq_request_arbiter.sv - round-robin arbiter sharing one bram_tree priority queue among clients
module pq_request_arbiter #(
    parameter  int NUM_CLIENTS = 4,
    parameter  int DATA_WIDTH  = 16,
    parameter  int OP_LATENCY  = 24,
    localparam int ID_WIDTH    = $clog2(NUM_CLIENTS)
) (
    input  logic                              CLK,
    input  logic                              RSTn,
    input  logic [NUM_CLIENTS-1:0]            i_req_valid,
    input  logic [2*NUM_CLIENTS-1:0]          i_req_op,
    input  logic [DATA_WIDTH*NUM_CLIENTS-1:0] i_req_data,
    output logic [NUM_CLIENTS-1:0]            o_req_ready,
    output logic                              o_rsp_valid,
    output logic [ID_WIDTH-1:0]               o_rsp_id,
    output logic                              o_rsp_err,
    output logic [DATA_WIDTH-1:0]             o_rsp_data,
    output logic                              o_busy,
    output logic                              o_pq_wrt,
    output logic                              o_pq_read,
    output logic [DATA_WIDTH-1:0]             o_pq_data,
    input  logic                              i_pq_full,
    input  logic                              i_pq_empty,
    input  logic [DATA_WIDTH-1:0]             i_pq_data
);
    localparam int CNT_W = (OP_LATENCY > 1) ? $clog2(OP_LATENCY) : 1;
    localparam logic [1:0] OP_ENQ = 2'b00;
    localparam logic [1:0] OP_DEQ = 2'b01;
    localparam logic [1:0] OP_REP = 2'b10;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                  state;
    logic [ID_WIDTH-1:0]     rr_ptr;
    logic [ID_WIDTH-1:0]     cur_id;
    logic [1:0]              cur_op;
    logic [DATA_WIDTH-1:0]   cur_key;
    logic [DATA_WIDTH-1:0]   root_q;
    logic [CNT_W-1:0]        wait_cnt;
    logic                    rsp_valid_q;
    logic                    rsp_err_q;
    logic [ID_WIDTH-1:0]     rsp_id_q;
    logic [DATA_WIDTH-1:0]   rsp_data_q;

    logic [NUM_CLIENTS-1:0]  grant;
    logic                    win_found;
    logic [ID_WIDTH-1:0]     win_id;
    logic [1:0]              win_op;
    logic [DATA_WIDTH-1:0]   win_key;
    logic                    cmd_err;
    logic                    issue_ok;

    // Search starts just after the last winner so every valid client is reached within NUM_CLIENTS grants.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        win_found = 1'b0;
        win_id    = '0;
        win_op    = '0;
        win_key   = '0;
        for (int k = 1; k <= NUM_CLIENTS; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_CLIENTS;
            if (!win_found && i_req_valid[idx]) begin
                win_found  = 1'b1;
                win_id     = ID_WIDTH'(idx);
                win_op     = i_req_op[2*idx +: 2];
                win_key    = i_req_data[DATA_WIDTH*idx +: DATA_WIDTH];
                grant[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        cmd_err = 1'b0;
        case (cur_op)
            OP_ENQ:         cmd_err = i_pq_full;
            OP_DEQ, OP_REP: cmd_err = i_pq_empty;
            default:        cmd_err = 1'b1;
        endcase
    end

    // Tree flags are only meaningful in ISSUE, so the command pulse is decoded from them in that cycle.
    assign issue_ok    = (state == ISSUE) && !cmd_err;
    assign o_pq_wrt    = issue_ok && (cur_op != OP_DEQ);
    assign o_pq_read   = issue_ok && (cur_op != OP_ENQ);
    assign o_pq_data   = issue_ok ? cur_key : '0;
    assign o_req_ready = (RSTn && state == IDLE) ? grant : '0;
    assign o_busy      = (state != IDLE);
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_rsp_id    = rsp_id_q;
    assign o_rsp_data  = rsp_data_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state       <= IDLE;
            rr_ptr      <= ID_WIDTH'(NUM_CLIENTS - 1);
            cur_id      <= '0;
            cur_op      <= '0;
            cur_key     <= '0;
            root_q      <= '0;
            wait_cnt    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        cur_id  <= win_id;
                        rr_ptr  <= win_id;
                        cur_op  <= win_op;
                        cur_key <= win_key;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cmd_err) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_id_q    <= cur_id;
                        rsp_data_q  <= '0;
                        state       <= RESP;
                    end else begin
                        root_q   <= (cur_op == OP_ENQ) ? '0 : i_pq_data;
                        wait_cnt <= CNT_W'(OP_LATENCY - 1);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_id_q    <= cur_id;
                        rsp_data_q  <= root_q;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: begin
                    rsp_err_q  <= 1'b0;
                    rsp_id_q   <= '0;
                    rsp_data_q <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pq_request_arbiter.sv
// tb/tb_pq_request_arbiter.sv - directed self-checking bench for pq_request_arbiter with a priority-queue model
module tb_pq_request_arbiter;
    localparam int NC  = 4;
    localparam int DW  = 16;
    localparam int OPL = 24;
    localparam int QSZ = 15;

    logic            CLK;
    logic            RSTn;
    logic [NC-1:0]   req_valid;
    logic [2*NC-1:0] req_op;
    logic [DW*NC-1:0] req_data;
    logic [NC-1:0]   req_ready;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic            rsp_err;
    logic [DW-1:0]   rsp_data;
    logic            busy;
    logic            pq_wrt;
    logic            pq_read;
    logic [DW-1:0]   pq_data;
    logic            pq_full;
    logic            pq_empty;
    logic [DW-1:0]   pq_root;

    int passed = 0;
    int total  = 0;
    int wrt_cnt = 0;
    int rd_cnt  = 0;
    int rsp_cnt = 0;

    pq_request_arbiter #(.NUM_CLIENTS(NC), .DATA_WIDTH(DW), .OP_LATENCY(OPL)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .i_req_valid(req_valid), .i_req_op(req_op), .i_req_data(req_data),
        .o_req_ready(req_ready), .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id),
        .o_rsp_err(rsp_err), .o_rsp_data(rsp_data), .o_busy(busy),
        .o_pq_wrt(pq_wrt), .o_pq_read(pq_read), .o_pq_data(pq_data),
        .i_pq_full(pq_full), .i_pq_empty(pq_empty), .i_pq_data(pq_root)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Max-first priority queue standing in for bram_tree.
    logic [DW-1:0] tmem [16];
    int            tcnt;
    int            best_idx;
    logic [DW-1:0] best_val;

    always_comb begin
        best_idx = 0;
        best_val = '0;
        for (int i = 0; i < 16; i++)
            if (i < tcnt && tmem[i] >= best_val) begin
                best_val = tmem[i];
                best_idx = i;
            end
    end

    assign pq_root  = best_val;
    assign pq_full  = (tcnt == QSZ);
    assign pq_empty = (tcnt == 0);

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) tcnt <= 0;
        else if (pq_wrt && !pq_read && tcnt < QSZ) begin
            tmem[tcnt] <= pq_data;
            tcnt <= tcnt + 1;
        end else if (!pq_wrt && pq_read && tcnt > 0) begin
            tmem[best_idx] <= tmem[tcnt-1];
            tcnt <= tcnt - 1;
        end else if (pq_wrt && pq_read && tcnt > 0) begin
            tmem[best_idx] <= pq_data;
        end
    end

    always @(posedge CLK) begin
        if (pq_wrt)    wrt_cnt <= wrt_cnt + 1;
        if (pq_read)   rd_cnt  <= rd_cnt + 1;
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    typedef struct {
        int         client;
        logic [1:0] op;
        logic [15:0] key;
        logic       exp_err;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic outs_zero(input string name);
        chk(name, |{req_ready, rsp_valid, rsp_id, rsp_err, rsp_data, busy, pq_wrt, pq_read, pq_data}, 0);
    endtask

    task automatic do_req(input int c, input logic [1:0] op, input logic [15:0] key,
                          input logic exp_err, input logic [15:0] exp_data);
        int n, lat, w0, r0;
        step();
        req_valid[c] = 1'b1;
        req_op[2*c +: 2] = op;
        req_data[16*c +: 16] = key;
        #1;
        n = 0;
        while (req_ready[c] !== 1'b1 && n < 50) begin step(); n++; end
        chk("req_grant", req_ready, 1 << c);
        w0 = wrt_cnt;
        r0 = rd_cnt;
        step();
        req_valid[c] = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 60) begin step(); lat++; end
        chk("rsp_latency", lat, exp_err ? 2 : 2 + OPL);
        chk("rsp_id", rsp_id, c);
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_data", rsp_data, exp_data);
        chk("wrt_pulses", wrt_cnt - w0, (!exp_err && op != 2'b01) ? 1 : 0);
        chk("read_pulses", rd_cnt - r0, (!exp_err && op != 2'b00) ? 1 : 0);
        step();
        chk("rsp_one_cycle", rsp_valid, 0);
        chk("busy_after_resp", busy, 0);
    endtask

    // All clients request together; grants must rotate 0..3 and each response must match its grant.
    task automatic rr_round(input logic [1:0] op, input logic [63:0] keys, input logic [63:0] exp);
        int n, lat;
        step();
        for (int i = 0; i < NC; i++) begin
            req_valid[i] = 1'b1;
            req_op[2*i +: 2] = op;
            req_data[16*i +: 16] = keys[16*i +: 16];
        end
        #1;
        for (int k = 0; k < NC; k++) begin
            n = 0;
            while (req_ready == '0 && n < 50) begin step(); n++; end
            chk("rr_grant", req_ready, 1 << k);
            step();
            req_valid[k] = 1'b0;
            lat = 1;
            while (rsp_valid !== 1'b1 && lat < 60) begin step(); lat++; end
            chk("rr_latency", lat, 2 + OPL);
            chk("rr_rsp_id", rsp_id, k);
            chk("rr_rsp_err", rsp_err, 0);
            chk("rr_rsp_data", rsp_data, exp[16*k +: 16]);
            step();
        end
    endtask

    initial begin
        int n, lat, rc0;
        RSTn = 1'b0;
        req_valid = '0;
        req_op = '0;
        req_data = '0;
        vecs[0] = '{1, 2'b01, 16'h0000, 1'b1, 16'h0000};
        vecs[1] = '{2, 2'b00, 16'h0100, 1'b0, 16'h0000};
        vecs[2] = '{2, 2'b01, 16'h0000, 1'b0, 16'h0100};
        vecs[3] = '{3, 2'b11, 16'h0055, 1'b1, 16'h0000};
        vecs[4] = '{0, 2'b10, 16'h0077, 1'b1, 16'h0000};

        step();
        step();
        outs_zero("reset_outputs");
        RSTn = 1'b1;
        step();
        chk("idle_busy", busy, 0);

        rr_round(2'b00, {16'd7, 16'd3, 16'd9, 16'd5}, 64'h0);
        rr_round(2'b01, 64'h0, {16'd3, 16'd5, 16'd7, 16'd9});
        chk("empty_after_rr", pq_empty, 1);

        for (int v = 0; v < 5; v++)
            do_req(vecs[v].client, vecs[v].op, vecs[v].key, vecs[v].exp_err, vecs[v].exp_data);
        chk("empty_after_deq", pq_empty, 1);

        for (int i = 0; i < QSZ; i++)
            do_req(i % NC, 2'b00, 16'h0010 + 16'(i), 1'b0, 16'h0000);
        chk("tree_full", pq_full, 1);
        do_req(0, 2'b00, 16'h0050, 1'b1, 16'h0000);
        do_req(1, 2'b10, 16'h0001, 1'b0, 16'h001e);

        step();
        req_valid[1] = 1'b1;
        req_op[3:2] = 2'b01;
        #1;
        n = 0;
        while (req_ready[1] !== 1'b1 && n < 50) begin step(); n++; end
        step();
        req_valid[1] = 1'b0;
        repeat (5) step();
        chk("busy_mid_wait", busy, 1);
        rc0 = rsp_cnt;
        req_valid = '1;
        req_op = '0;
        req_data = {16'h0004, 16'h0003, 16'h0002, 16'h00aa};
        RSTn = 1'b0;
        #1;
        outs_zero("async_reset_outputs");
        step();
        step();
        RSTn = 1'b1;
        #1;
        chk("first_grant_after_reset", req_ready, 4'b0001);
        step();
        req_valid = '0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 60) begin step(); lat++; end
        chk("post_reset_latency", lat, 2 + OPL);
        chk("post_reset_rsp_id", rsp_id, 0);
        chk("post_reset_rsp_err", rsp_err, 0);
        step();
        chk("dropped_inflight_rsp", rsp_cnt - rc0, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
